pe_operand_feeder: RTL and testbench



---
 rtl/definition.sv | 4 +
 rtl/pe_operand_feeder.sv | 149 ++++++++++++++
 tb/tb_pe_operand_feeder.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/definition.sv
// Shared width definitions for the conv/attention processing arrays.
package definition;
  localparam int unsigned conv4_width = 8;
endpackage

// File: rtl/pe_operand_feeder.sv
// Operand sequencer for one PE_2D: buffers an operand vector, replays it under
// o_en, drains zero pairs until the PE flags (or times out), then returns the result.
module pe_operand_feeder #(
  parameter int unsigned WIDTH   = definition::conv4_width,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_r1,
  input  logic [WIDTH-1:0]     s_r2,
  input  logic                 s_last,
  output logic                 o_en,
  output logic [WIDTH-1:0]     o_r1,
  output logic [WIDTH-1:0]     o_r2,
  input  logic [2*WIDTH-1:0]   i_mat,
  input  logic                 i_flag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_data,
  output logic                 m_err
);

  localparam int unsigned CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PAIR_W = 2 * WIDTH;

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, RESULT} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [CNT_W-1:0]    len_m1_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [PAIR_W-1:0]   buf_q [DEPTH];
  logic                s_ready_q;
  logic                o_en_q;
  logic [WIDTH-1:0]    o_r1_q;
  logic [WIDTH-1:0]    o_r2_q;
  logic                m_valid_q;
  logic [PAIR_W-1:0]   m_data_q;
  logic                m_err_q;

  logic                beat_acc;
  logic                beat_end;
  logic [CNT_W-1:0]    rd_inc;

  // s_ready_q is only ever set for a cycle spent in LOAD, so it qualifies acceptance.
  assign beat_acc = s_valid && s_ready_q;
  assign beat_end = s_last || (wr_cnt_q == CNT_W'(DEPTH - 1));
  assign rd_inc   = rd_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (beat_acc) begin
      buf_q[wr_cnt_q] <= {s_r1, s_r2};
    end
  end

  // Outputs are registered for the state being entered, so the first pair is
  // presented directly from the beat when the vector is a single element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      len_m1_q  <= '0;
      to_cnt_q  <= '0;
      s_ready_q <= 1'b0;
      o_en_q    <= 1'b0;
      o_r1_q    <= '0;
      o_r2_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          s_ready_q <= 1'b1;
          if (beat_acc) begin
            if (beat_end) begin
              state_q   <= STREAM;
              len_m1_q  <= wr_cnt_q;
              wr_cnt_q  <= '0;
              rd_cnt_q  <= '0;
              s_ready_q <= 1'b0;
              o_en_q    <= 1'b1;
              if (wr_cnt_q == '0) begin
                o_r1_q <= s_r1;
                o_r2_q <= s_r2;
              end else begin
                {o_r1_q, o_r2_q} <= buf_q[0];
              end
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (rd_cnt_q == len_m1_q) begin
            state_q  <= DRAIN;
            rd_cnt_q <= '0;
            to_cnt_q <= '0;
            o_r1_q   <= '0;
            o_r2_q   <= '0;
          end else begin
            rd_cnt_q         <= rd_inc;
            {o_r1_q, o_r2_q} <= buf_q[rd_inc];
          end
        end
        DRAIN: begin
          if (i_flag) begin
            state_q   <= RESULT;
            o_en_q    <= 1'b0;
            m_valid_q <= 1'b1;
            m_data_q  <= i_mat;
            m_err_q   <= 1'b0;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_q   <= RESULT;
            o_en_q    <= 1'b0;
            m_valid_q <= 1'b1;
            m_data_q  <= '0;
            m_err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RESULT: begin
          if (m_ready) begin
            state_q   <= LOAD;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign o_en    = o_en_q;
  assign o_r1    = o_r1_q;
  assign o_r2    = o_r2_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: MAC-style PE model, timeline reference model and
// a per-cycle output compare, plus directed scenarios with literal results.
module tb_pe_operand_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } pair_t;

  logic           clk     = 1'b0;
  logic           rst     = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_r1    = '0;
  logic [W-1:0]   s_r2    = '0;
  logic           s_last  = 1'b0;
  logic           o_en;
  logic [W-1:0]   o_r1;
  logic [W-1:0]   o_r2;
  logic [2*W-1:0] i_mat   = '0;
  logic           i_flag  = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [2*W-1:0] m_data;
  logic           m_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_operand_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_r1    (s_r1),
    .s_r2    (s_r2),
    .s_last  (s_last),
    .o_en    (o_en),
    .o_r1    (o_r1),
    .o_r2    (o_r2),
    .i_mat   (i_mat),
    .i_flag  (i_flag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_err   (m_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pair_t mk(input int a, input int b);
    pair_t p;
    p.r1 = W'(a);
    p.r2 = W'(b);
    return p;
  endfunction

  // Reference model: a completed vector becomes a timeline of presented pairs
  // followed by the zero drain pairs; the result is the dot product or a timeout.
  pair_t          vec_q[$];
  pair_t          tl[$];
  pair_t          mp;
  logic           exp_s_ready = 1'b0;
  logic           exp_o_en    = 1'b0;
  logic           exp_mv      = 1'b0;
  logic           exp_me      = 1'b0;
  logic [W-1:0]   exp_r1      = '0;
  logic [W-1:0]   exp_r2      = '0;
  logic [2*W-1:0] exp_md      = '0;
  logic [2*W-1:0] res_md      = '0;
  logic           res_me      = 1'b0;
  logic [2*W-1:0] msum        = '0;
  int             fd_arr[256];
  int             nv          = 0;
  int             vec_idx     = 0;
  int             pe_fd       = 0;
  int             pe_len      = 0;
  int             mdrain      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q.delete();
      tl.delete();
      exp_s_ready = 1'b0;
      exp_o_en    = 1'b0;
      exp_mv      = 1'b0;
      exp_r1      = '0;
      exp_r2      = '0;
    end else if (exp_mv) begin
      if (m_ready) begin
        exp_mv      = 1'b0;
        exp_s_ready = 1'b1;
      end
    end else if (tl.size() > 0) begin
      mp       = tl.pop_front();
      exp_o_en = 1'b1;
      exp_r1   = mp.r1;
      exp_r2   = mp.r2;
    end else if (exp_o_en) begin
      exp_o_en = 1'b0;
      exp_r1   = '0;
      exp_r2   = '0;
      exp_mv   = 1'b1;
      exp_md   = res_md;
      exp_me   = res_me;
    end else if (exp_s_ready && s_valid) begin
      vec_q.push_back({s_r1, s_r2});
      if (s_last || vec_q.size() == D) begin
        msum = '0;
        foreach (vec_q[i]) begin
          tl.push_back(vec_q[i]);
          msum = msum + (2*W)'(vec_q[i].r1) * (2*W)'(vec_q[i].r2);
        end
        pe_fd  = fd_arr[vec_idx];
        pe_len = vec_q.size();
        vec_idx++;
        if (pe_fd >= 1 && pe_fd <= int'(TO)) begin
          mdrain = pe_fd;
          res_md = msum;
          res_me = 1'b0;
        end else begin
          mdrain = TO;
          res_md = '0;
          res_me = 1'b1;
        end
        repeat (mdrain) tl.push_back('0);
        vec_q.delete();
        mp          = tl.pop_front();
        exp_o_en    = 1'b1;
        exp_r1      = mp.r1;
        exp_r2      = mp.r2;
        exp_s_ready = 1'b0;
      end
    end else begin
      exp_s_ready = 1'b1;
    end
  end

  // PE model: accumulates every enabled pair, raises its flag pe_fd cycles into
  // the drain, and toggles the flag randomly where the feeder must ignore it.
  int             cyc = 0;
  logic [2*W-1:0] acc = '0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      cyc    = 0;
      acc    = '0;
      i_flag = 1'b0;
      i_mat  = '0;
    end else if (o_en) begin
      cyc++;
      acc   = acc + (2*W)'(o_r1) * (2*W)'(o_r2);
      i_mat = acc;
      if (cyc <= pe_len) i_flag = 1'($urandom_range(0, 1));
      else               i_flag = (pe_fd != 0) && (cyc == pe_len + pe_fd);
    end else begin
      cyc    = 0;
      acc    = '0;
      i_flag = 1'($urandom_range(0, 1));
      i_mat  = (2*W)'($urandom);
    end
  end

  int en_cnt = 0;
  always @(posedge clk) if (o_en) en_cnt++;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_o_en", 32'(o_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
    end else begin
      chk("s_ready", 32'(s_ready), 32'(exp_s_ready));
      chk("o_en", 32'(o_en), 32'(exp_o_en));
      chk("o_r1", 32'(o_r1), 32'(exp_r1));
      chk("o_r2", 32'(o_r2), 32'(exp_r2));
      chk("m_valid", 32'(m_valid), 32'(exp_mv));
      if (exp_mv) begin
        chk("m_data", 32'(m_data), 32'(exp_md));
        chk("m_err", 32'(m_err), 32'(exp_me));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      s_valid = 1'b0;
      s_last  = 1'($urandom_range(0, 1));
      s_r1    = W'($urandom);
      s_r2    = W'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_r1    = a;
    s_r2    = b;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("beat_accept", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic set_next_fd(input int fd);
    fd_arr[nv] = fd;
    nv++;
  endtask

  task automatic send_vec(input pair_t beats[$], input bit mark_last, input int fd, input int max_gap);
    set_next_fd(fd);
    foreach (beats[i]) begin
      idle((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      send_beat(beats[i].r1, beats[i].r2, mark_last && (i == beats.size() - 1));
    end
  endtask

  task automatic wait_result(input int hold, output logic [2*W-1:0] data, output logic err);
    int n = 0;
    m_ready = (hold == 0);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("result_valid", 32'(m_valid), 32'd1);
    data = m_data;
    err  = m_err;
    repeat (hold) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [2*W-1:0] d;
    logic           e;
    int             base;
    int             len;
    int             fd;
    int             sel;
    bit             ml;
    pair_t          v[$];

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_o_r1", 32'(o_r1), 32'd0);
    chk("rst_o_r2", 32'(o_r2), 32'd0);
    rst = 1'b0;

    // Four-element vector, flag in the second drain cycle.
    base = en_cnt;
    v = '{mk(1, 3), mk(2, 4), mk(3, 5), mk(4, 6)};
    send_vec(v, 1'b1, 2, 0);
    wait_result(0, d, e);
    chk("t1_data", 32'(d), 32'd50);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_en_cycles", 32'(en_cnt - base), 32'd6);

    // Single element.
    base = en_cnt;
    v = '{mk(7, 9)};
    send_vec(v, 1'b1, 1, 0);
    wait_result(0, d, e);
    chk("t2_data", 32'(d), 32'd63);
    chk("t2_en_cycles", 32'(en_cnt - base), 32'd2);

    // Implicit last at DEPTH; the fifth beat waits for the result handshake.
    v = '{mk(1, 1), mk(2, 2), mk(3, 3), mk(4, 4)};
    send_vec(v, 1'b0, 2, 0);
    chk("t3_beat5_blocked", 32'(s_ready), 32'd0);
    set_next_fd(3);
    fork
      send_beat(W'(5), W'(5), 1'b0);
      wait_result(0, d, e);
    join
    chk("t3_data", 32'(d), 32'd30);
    chk("t3_err", 32'(e), 32'd0);
    send_beat(W'(6), W'(6), 1'b1);
    wait_result(1, d, e);
    chk("t3b_data", 32'(d), 32'd61);

    // PE never flags: full timeout.
    base = en_cnt;
    v = '{mk(2, 3), mk(4, 5)};
    send_vec(v, 1'b1, 0, 0);
    wait_result(2, d, e);
    chk("t4_data", 32'(d), 32'd0);
    chk("t4_err", 32'(e), 32'd1);
    chk("t4_en_cycles", 32'(en_cnt - base), 32'd18);

    // Flag coincides with the last timeout cycle: flag wins.
    base = en_cnt;
    v = '{mk(3, 3)};
    send_vec(v, 1'b1, TO, 0);
    wait_result(0, d, e);
    chk("t5_data", 32'(d), 32'd9);
    chk("t5_err", 32'(e), 32'd0);
    chk("t5_en_cycles", 32'(en_cnt - base), 32'd17);

    // Result held off by the consumer for five cycles.
    v = '{mk(10, 10), mk(1, 2)};
    send_vec(v, 1'b1, TO - 1, 0);
    wait_result(5, d, e);
    chk("t6_data", 32'(d), 32'd102);

    // Reset during the second stream cycle, then a fresh vector.
    v = '{mk(9, 9), mk(8, 8), mk(7, 7)};
    send_vec(v, 1'b1, 3, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_o_en", 32'(o_en), 32'd0);
    chk("t7_async_m_valid", 32'(m_valid), 32'd0);
    chk("t7_async_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    v = '{mk(2, 2), mk(3, 3)};
    send_vec(v, 1'b1, 1, 0);
    wait_result(0, d, e);
    chk("t7_data", 32'(d), 32'd13);
    chk("t7_err", 32'(e), 32'd0);

    // Randomized vectors, gaps, flag delays and consumer backpressure.
    for (int k = 0; k < 40; k++) begin
      len = int'($urandom_range(1, D));
      v.delete();
      for (int i = 0; i < len; i++) begin
        v.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
      end
      ml  = (len < int'(D)) ? 1'b1 : 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       fd = 0;
        1:       fd = TO;
        2:       fd = TO + 3;
        default: fd = int'($urandom_range(1, TO - 1));
      endcase
      send_vec(v, ml, fd, 2);
      wait_result(int'($urandom_range(0, 3)), d, e);
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
